// File: rtl/apb_reg_bridge_pkg.sv
// Shared types and constants for the APB register bridge.
// Contents: FSM state enum, address field positions, wait-counter width and
// the latched per-transfer control word.
package apb_bridge_pkg;

   localparam int unsigned APB_IDX_LSB = 2;
   localparam int unsigned APB_IDX_W   = 4;
   localparam int unsigned APB_WIN_LSB = 6;
   localparam int unsigned APB_WAIT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } bridge_state_e;

   // Control captured at the setup sample and held for the whole transfer.
   typedef struct packed {
      logic                 write;
      logic                 hit;
      logic [APB_IDX_W-1:0] idx;
   } xfer_ctl_t;

endpackage

// File: rtl/apb_reg_bridge_if.sv
// Bus bundle between the APB master side and the register bridge.
// APB side  : psel, penable, pwrite, paddr, pwdata -> pready, pslverr, prdata
// Peripheral: base_addr, rdata -> wr, dr, wdata
// Modports  : master (system bus + peripheral model), slave (bridge).
interface apb_reg_bridge_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned N_REGS = 4
) ();
   import apb_bridge_pkg::*;

   logic                          psel;
   logic                          penable;
   logic                          pwrite;
   logic [ADDR_W-1:0]             paddr;
   logic [DATA_W-1:0]             pwdata;
   logic                          pready;
   logic                          pslverr;
   logic [DATA_W-1:0]             prdata;
   logic [ADDR_W-APB_WIN_LSB-1:0] base_addr;
   logic [N_REGS*DATA_W-1:0]      rdata;
   logic [N_REGS-1:0]             wr;
   logic [N_REGS-1:0]             dr;
   logic [DATA_W-1:0]             wdata;

   modport master (
      output psel, penable, pwrite, paddr, pwdata, base_addr, rdata,
      input  pready, pslverr, prdata, wr, dr, wdata
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata, base_addr, rdata,
      output pready, pslverr, prdata, wr, dr, wdata
   );

endinterface

// File: rtl/apb_reg_bridge_decode.sv
// Combinational window/index decode for the register bridge.
// Ports: paddr (byte address), base_addr (window base) -> hit_c, idx_c.
// hit_c is set when the window matches and the index names an implemented register.
module apb_reg_decode
   import apb_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned N_REGS = 4
) (
   input  logic [ADDR_W-1:0]             paddr,
   input  logic [ADDR_W-APB_WIN_LSB-1:0] base_addr,
   output logic                          hit_c,
   output logic [APB_IDX_W-1:0]          idx_c
);

   // Byte-lane bits carry no meaning for word registers.
   logic unused_lsbs;
   assign unused_lsbs = ^paddr[APB_IDX_LSB-1:0];

   assign idx_c = paddr[APB_IDX_LSB +: APB_IDX_W];
   assign hit_c = (paddr[ADDR_W-1:APB_WIN_LSB] == base_addr) && (32'(idx_c) < N_REGS);

endmodule

// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end decoding a base-addressed window of up to 16 word registers.
// Ports: i_PCLK, i_PRESETn (async, active-low), bus (apb_reg_bridge_if.slave).
// Emits one-cycle one-hot write/read strobes, a registered read-data mux and
// PREADY after WAIT_CYCLES extra wait states. All outputs are registered.
// Build option: define APB_BRIDGE_PSLVERR_EN to flag misses on pslverr;
// otherwise pslverr stays 0 and misses complete silently.
module apb_reg_bridge
   import apb_bridge_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned N_REGS      = 4,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic            i_PCLK,
   input  logic            i_PRESETn,
   apb_reg_bridge_if.slave bus
);

   bridge_state_e         state_q, state_nx;
   xfer_ctl_t             ctl_q, ctl_nx;
   logic [APB_WAIT_W-1:0] cnt_q, cnt_nx;

   logic                  pready_q, pready_nx;
   logic                  pslverr_q, pslverr_nx;
   logic [DATA_W-1:0]     prdata_q, prdata_nx;
   logic [DATA_W-1:0]     wdata_q, wdata_nx;
   logic [N_REGS-1:0]     wr_q, wr_nx;
   logic [N_REGS-1:0]     dr_q, dr_nx;

   logic                  hit_c;
   logic [APB_IDX_W-1:0]  idx_c;
   logic                  setup_c;
   logic                  latch_c;
   logic                  enter_done_c;
   logic [DATA_W-1:0]     rd_sel_c;

   apb_reg_decode #(
      .ADDR_W (ADDR_W),
      .N_REGS (N_REGS)
   ) u_decode (
      .paddr     (bus.paddr),
      .base_addr (bus.base_addr),
      .hit_c     (hit_c),
      .idx_c     (idx_c)
   );

   assign setup_c = bus.psel & ~bus.penable;

   // Read-data mux over the implemented registers only.
   always_comb begin
      rd_sel_c = '0;
      for (int unsigned k = 0; k < N_REGS; k++) begin
         if (ctl_q.idx == APB_IDX_W'(k)) begin
            rd_sel_c = bus.rdata[k*DATA_W +: DATA_W];
         end
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      state_nx     = state_q;
      ctl_nx       = ctl_q;
      cnt_nx       = cnt_q;
      wdata_nx     = wdata_q;
      pready_nx    = 1'b0;
      pslverr_nx   = 1'b0;
      prdata_nx    = '0;
      wr_nx        = '0;
      dr_nx        = '0;
      latch_c      = 1'b0;
      enter_done_c = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (setup_c) begin
               state_nx = ACCESS;
               latch_c  = 1'b1;
            end
         end
         ACCESS: begin
            if (!bus.psel) begin
               state_nx = IDLE;
            end else if (bus.penable) begin
               if (WAIT_CYCLES > 0) begin
                  state_nx = WAIT;
                  cnt_nx   = APB_WAIT_W'(WAIT_CYCLES - 1);
               end else begin
                  state_nx     = DONE;
                  enter_done_c = 1'b1;
               end
            end
         end
         WAIT: begin
            if (!bus.psel) begin
               state_nx = IDLE;
            end else if (cnt_q == '0) begin
               state_nx     = DONE;
               enter_done_c = 1'b1;
            end else begin
               cnt_nx = cnt_q - APB_WAIT_W'(1);
            end
         end
         DONE: begin
            // A setup overlapping the completion cycle chains straight into ACCESS.
            if (setup_c) begin
               state_nx = ACCESS;
               latch_c  = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      // Setup sample: capture the transfer and fire the read strobe into ACCESS.
      if (latch_c) begin
         ctl_nx.write = bus.pwrite;
         ctl_nx.hit   = hit_c;
         ctl_nx.idx   = idx_c;
         wdata_nx     = bus.pwdata;
         if (hit_c && !bus.pwrite) begin
            dr_nx = N_REGS'(1) << idx_c;
         end
      end

      // Completion: ready, write strobe and read data all land in DONE.
      if (enter_done_c) begin
         pready_nx = 1'b1;
         if (ctl_q.hit && ctl_q.write) begin
            wr_nx = N_REGS'(1) << ctl_q.idx;
         end
         if (ctl_q.hit && !ctl_q.write) begin
            prdata_nx = rd_sel_c;
         end
`ifdef APB_BRIDGE_PSLVERR_EN
         pslverr_nx = ~ctl_q.hit;
`else
         pslverr_nx = 1'b0;
`endif
      end
   end

   // State and output registers.
   always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
      if (!i_PRESETn) begin
         state_q   <= IDLE;
         ctl_q     <= '0;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         wdata_q   <= '0;
         wr_q      <= '0;
         dr_q      <= '0;
      end else begin
         state_q   <= state_nx;
         ctl_q     <= ctl_nx;
         cnt_q     <= cnt_nx;
         pready_q  <= pready_nx;
         pslverr_q <= pslverr_nx;
         prdata_q  <= prdata_nx;
         wdata_q   <= wdata_nx;
         wr_q      <= wr_nx;
         dr_q      <= dr_nx;
      end
   end

   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;
   assign bus.prdata  = prdata_q;
   assign bus.wdata   = wdata_q;
   assign bus.wr      = wr_q;
   assign bus.dr      = dr_q;

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Self-checking bench for apb_reg_bridge: two instances (4 regs / no waits and
// 3 regs / 3 waits) driven by directed and randomized APB transfers, checked
// against a transaction-level expectation computed from the address rules.
module tb_apb_reg_bridge;

   localparam int unsigned DW  = 8;
   localparam int unsigned AW  = 16;
   localparam int unsigned NR0 = 4;
   localparam int unsigned WT0 = 0;
   localparam int unsigned NR1 = 3;
   localparam int unsigned WT1 = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   apb_reg_bridge_if #(.DATA_W(DW), .ADDR_W(AW), .N_REGS(NR0)) bus0 ();
   apb_reg_bridge_if #(.DATA_W(DW), .ADDR_W(AW), .N_REGS(NR1)) bus1 ();

   apb_reg_bridge #(.DATA_W(DW), .ADDR_W(AW), .N_REGS(NR0), .WAIT_CYCLES(WT0)) dut0 (
      .i_PCLK(clk), .i_PRESETn(rst_n), .bus(bus0));
   apb_reg_bridge #(.DATA_W(DW), .ADDR_W(AW), .N_REGS(NR1), .WAIT_CYCLES(WT1)) dut1 (
      .i_PCLK(clk), .i_PRESETn(rst_n), .bus(bus1));

   int checks   = 0;
   int failures = 0;

   logic [9:0] base_v [0:1];
   logic [7:0] rval   [0:1][0:3];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit err_on_miss();
`ifdef APB_BRIDGE_PSLVERR_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input int d, input logic sel, input logic en, input logic wr,
                        input logic [15:0] a, input logic [7:0] wd);
      if (d == 0) begin
         bus0.psel = sel; bus0.penable = en; bus0.pwrite = wr; bus0.paddr = a; bus0.pwdata = wd;
      end else begin
         bus1.psel = sel; bus1.penable = en; bus1.pwrite = wr; bus1.paddr = a; bus1.pwdata = wd;
      end
   endtask

   task automatic load_periph(input int d);
      if (d == 0) begin
         bus0.base_addr = base_v[0];
         for (int k = 0; k < int'(NR0); k++) bus0.rdata[k*DW +: DW] = rval[0][k];
      end else begin
         bus1.base_addr = base_v[1];
         for (int k = 0; k < int'(NR1); k++) bus1.rdata[k*DW +: DW] = rval[1][k];
      end
   endtask

   task automatic sample(input int d, output logic [15:0] wr, output logic [15:0] dr,
                         output logic rdy, output logic err, output logic [7:0] prd,
                         output logic [7:0] wdt);
      if (d == 0) begin
         wr = 16'(bus0.wr); dr = 16'(bus0.dr); rdy = bus0.pready; err = bus0.pslverr;
         prd = bus0.prdata; wdt = bus0.wdata;
      end else begin
         wr = 16'(bus1.wr); dr = 16'(bus1.dr); rdy = bus1.pready; err = bus1.pslverr;
         prd = bus1.prdata; wdt = bus1.wdata;
      end
   endtask

   // One APB transfer. abort_at > 0 drops PSEL after that many enable-phase samples.
   // b2b = 1 issues the setup in the completion cycle of the previous transfer.
   task automatic xfer(input string tag, input int d, input bit wr_en, input logic [15:0] addr,
                       input logic [7:0] wd, input bit b2b, input int abort_at);
      int wt, nr, idx, done_at, last, bad;
      bit hit;
      logic [15:0] exp_dr, exp_wr, s_wr, s_dr;
      logic [7:0]  exp_rd, s_prd, s_wdt;
      logic        exp_err, s_rdy, s_err;
      wt      = (d == 0) ? int'(WT0) : int'(WT1);
      nr      = (d == 0) ? int'(NR0) : int'(NR1);
      idx     = int'(addr[5:2]);
      hit     = (addr[15:6] == base_v[d]) && (idx < nr);
      exp_dr  = (hit && !wr_en) ? (16'd1 << idx) : 16'd0;
      exp_wr  = (hit && wr_en) ? (16'd1 << idx) : 16'd0;
      exp_rd  = 8'd0;
      if (hit && !wr_en) exp_rd = rval[d][idx];
      exp_err = !hit && err_on_miss();
      done_at = 2 + wt;
      last    = (abort_at > 0) ? abort_at + 3 : done_at;
      bad     = 0;
      if (!b2b) @(negedge clk);
      load_periph(d);
      drive(d, 1'b1, 1'b0, wr_en, addr, wd);
      for (int j = 1; j <= last; j++) begin
         @(negedge clk);
         sample(d, s_wr, s_dr, s_rdy, s_err, s_prd, s_wdt);
         if (j == 1) check_eq({tag, "_dr"}, 32'(s_dr), 32'(exp_dr));
         else if (s_dr != 16'd0) bad++;
         if (abort_at == 0 && j == done_at) begin
            check_eq({tag, "_rdy"},    32'(s_rdy),  32'(1));
            check_eq({tag, "_wr"},     32'(s_wr),   32'(exp_wr));
            check_eq({tag, "_prdata"}, 32'(s_prd),  32'(exp_rd));
            check_eq({tag, "_slverr"}, 32'(s_err),  32'(exp_err));
            check_eq({tag, "_wdata"},  32'(s_wdt),  32'(wd));
         end else if (s_rdy || s_err || s_wr != 16'd0 || s_prd != 8'd0) begin
            bad++;
         end
         if ((abort_at > 0 && j >= abort_at) || j == done_at) drive(d, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
         else drive(d, 1'b1, 1'b1, wr_en, addr, wd);
      end
      check_eq({tag, "_quiet"}, 32'(bad), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] s_wr, s_dr;
      logic [7:0]  s_prd, s_wdt;
      logic        s_rdy, s_err;
      int          d, prev_d, abort_at, bad, wt;
      bit          prev_ok, b2b, wr_en;
      logic [15:0] addr;
      logic [9:0]  win;

      base_v[0] = 10'h0;
      base_v[1] = 10'h0;
      for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) rval[i][k] = 8'($urandom);
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      load_periph(0);
      load_periph(1);

      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         sample(i, s_wr, s_dr, s_rdy, s_err, s_prd, s_wdt);
         check_eq($sformatf("reset_outs%0d", i), 32'({s_rdy, s_err, s_wr, s_dr, s_prd, s_wdt}) , 32'(0));
      end
      rst_n = 1'b1;

      // Directed scenarios.
      xfer("wr_a5", 0, 1'b1, 16'h0004, 8'hA5, 1'b0, 0);
      rval[1][2] = 8'h3C;
      xfer("rd_wait", 1, 1'b0, 16'h0008, 8'h5E, 1'b0, 0);
      xfer("miss_win", 0, 1'b1, 16'h0040, 8'h5A, 1'b0, 0);
      xfer("oor_idx", 1, 1'b0, 16'h000C, 8'h19, 1'b0, 0);
      xfer("b2b_wr", 0, 1'b1, 16'h0000, 8'h11, 1'b0, 0);
      xfer("b2b_rd", 0, 1'b0, 16'h0004, 8'h22, 1'b1, 0);
      xfer("abort_acc", 0, 1'b1, 16'h0008, 8'h33, 1'b0, 1);
      xfer("abort_wait", 1, 1'b1, 16'h0004, 8'h44, 1'b0, 2);
      xfer("post_abort", 1, 1'b0, 16'h0000, 8'h55, 1'b0, 0);

      // Reset asserted while the 3-wait instance sits in WAIT.
      @(negedge clk);
      load_periph(1);
      drive(1, 1'b1, 1'b0, 1'b1, 16'h0004, 8'h77);
      @(negedge clk);
      drive(1, 1'b1, 1'b1, 1'b1, 16'h0004, 8'h77);
      @(negedge clk);
      sample(1, s_wr, s_dr, s_rdy, s_err, s_prd, s_wdt);
      check_eq("rstw_latched", 32'(s_wdt), 32'(8'h77));
      #1 rst_n = 1'b0;
      #1 sample(1, s_wr, s_dr, s_rdy, s_err, s_prd, s_wdt);
      check_eq("rstw_async", 32'({s_rdy, s_err, s_wr, s_dr, s_prd, s_wdt}), 32'(0));
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         sample(1, s_wr, s_dr, s_rdy, s_err, s_prd, s_wdt);
         if ({s_rdy, s_err, s_wr, s_dr, s_prd, s_wdt} != '0) bad++;
      end
      check_eq("rstw_hold", 32'(bad), 32'(0));
      rst_n = 1'b1;
      xfer("post_rst", 1, 1'b1, 16'h0004, 8'h66, 1'b0, 0);

      // Randomized transfers on both instances.
      prev_d  = -1;
      prev_ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         d     = int'($urandom_range(0, 1));
         wt    = (d == 0) ? int'(WT0) : int'(WT1);
         b2b   = prev_ok && (prev_d == d) && ($urandom_range(0, 1) == 1);
         wr_en = 1'($urandom_range(0, 1));
         if (!b2b) base_v[d] = 10'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) rval[d][k] = 8'($urandom);
         win  = ($urandom_range(0, 3) != 0) ? base_v[d] : 10'($urandom);
         addr = {win, 4'($urandom_range(0, 5)), 2'($urandom)};
         abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 1 + wt)) : 0;
         xfer($sformatf("rnd%0d", n), d, wr_en, addr, 8'($urandom), b2b, abort_at);
         prev_d  = d;
         prev_ok = (abort_at == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
